// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: write-back arbiter and load scoreboard for the 2r1w register file.
// The single write port is shared between the ALU result path and the load-return
// path. A load return always wins the port. An ALU result that loses the port is
// parked in a small skid FIFO. A per-register pending-load scoreboard drives the
// decode stall.
//
// Ports
//   clk, rst_n                         clock, async active-low reset
//   i_alu_valid/addr/data, o_alu_ready ALU result offer and acceptance
//   i_ld_issue/issue_addr, o_ld_issue_ready  load issue (marks destination pending)
//   i_ld_valid/addr/data               load return (no backpressure)
//   i_rs1_addr, i_rs2_addr, o_stall    decode-stage hazard check
//   o_wr_en/addr/data                  registered register-file write port
//   o_err                              sticky protocol error
//
// Optional build macro RF_WB_ERR_EN: when it is defined, o_err flags a return to a
// register with no pending load and an issue while o_ld_issue_ready=0. Without the
// macro, o_err is tied to 0.
module rf_wb_arbiter #(
  parameter int WIDTH      = 32,
  parameter int DEPTH      = 32,
  parameter int FIFO_DEPTH = 2,
  localparam int AW        = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_alu_valid,
  output logic             o_alu_ready,
  input  logic [AW-1:0]    i_alu_addr,
  input  logic [WIDTH-1:0] i_alu_data,
  input  logic             i_ld_issue,
  input  logic [AW-1:0]    i_ld_issue_addr,
  output logic             o_ld_issue_ready,
  input  logic             i_ld_valid,
  input  logic [AW-1:0]    i_ld_addr,
  input  logic [WIDTH-1:0] i_ld_data,
  input  logic [AW-1:0]    i_rs1_addr,
  input  logic [AW-1:0]    i_rs2_addr,
  output logic             o_stall,
  output logic             o_wr_en,
  output logic [AW-1:0]    o_wr_addr,
  output logic [WIDTH-1:0] o_wr_data,
  output logic             o_err
);

  localparam int PW = $clog2(FIFO_DEPTH);

  logic [DEPTH-1:0]      pending, pending_nxt;
  logic [AW-1:0]         fifo_addr [FIFO_DEPTH];
  logic [WIDTH-1:0]      fifo_data [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] fifo_vld;
  logic [PW-1:0]         rd_ptr, wr_ptr;

  logic fifo_empty, fifo_full, alu_acc, iss_acc;
  logic take_fifo, take_alu, push;

  // Per-slot valid bits: the slot under rd_ptr is empty only when the whole FIFO
  // is empty, and the slot under wr_ptr is occupied only when the FIFO is full.
  assign fifo_empty = !fifo_vld[rd_ptr];
  assign fifo_full  = fifo_vld[wr_ptr];

  // Holding ALU results for a register with an outstanding load prevents a
  // younger ALU write from being overwritten by the older load.
  assign o_alu_ready      = !fifo_full && !pending[i_alu_addr];
  assign o_ld_issue_ready = !pending[i_ld_issue_addr];
  assign alu_acc          = i_alu_valid && o_alu_ready;
  assign iss_acc          = i_ld_issue && o_ld_issue_ready;

  assign take_fifo = !i_ld_valid && !fifo_empty;
  assign take_alu  = !i_ld_valid && fifo_empty && alu_acc;
  assign push      = alu_acc && !take_alu;

  always_comb begin
    pending_nxt = pending;
    if (i_ld_valid) pending_nxt[i_ld_addr] = 1'b0;
    if (iss_acc && (i_ld_issue_addr != '0)) pending_nxt[i_ld_issue_addr] = 1'b1;
  end

  // The entry in the output register is covered by the register-file write
  // bypass, so only the scoreboard and the FIFO contents are checked here.
  always_comb begin
    o_stall = 1'b0;
    if (i_rs1_addr != '0 && pending[i_rs1_addr]) o_stall = 1'b1;
    if (i_rs2_addr != '0 && pending[i_rs2_addr]) o_stall = 1'b1;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (fifo_vld[i] && i_rs1_addr != '0 && fifo_addr[i] == i_rs1_addr) o_stall = 1'b1;
      if (fifo_vld[i] && i_rs2_addr != '0 && fifo_addr[i] == i_rs2_addr) o_stall = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending   <= '0;
      fifo_vld  <= '0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      o_wr_en   <= 1'b0;
      o_wr_addr <= '0;
      o_wr_data <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_addr[i] <= '0;
        fifo_data[i] <= '0;
      end
    end else begin
      pending <= pending_nxt;

      // Writes to x0 still consume their slot but never assert the write enable.
      if (i_ld_valid) begin
        o_wr_en   <= (i_ld_addr != '0);
        o_wr_addr <= i_ld_addr;
        o_wr_data <= i_ld_data;
      end else if (take_fifo) begin
        o_wr_en   <= (fifo_addr[rd_ptr] != '0);
        o_wr_addr <= fifo_addr[rd_ptr];
        o_wr_data <= fifo_data[rd_ptr];
      end else if (take_alu) begin
        o_wr_en   <= (i_alu_addr != '0);
        o_wr_addr <= i_alu_addr;
        o_wr_data <= i_alu_data;
      end else begin
        o_wr_en <= 1'b0;
      end

      // Push and pop in one cycle never touch the same slot: a push needs a
      // non-full FIFO, a pop a non-empty one, so the pointers differ.
      if (take_fifo) begin
        fifo_vld[rd_ptr] <= 1'b0;
        rd_ptr           <= rd_ptr + PW'(1);
      end
      if (push) begin
        fifo_vld[wr_ptr]  <= 1'b1;
        fifo_addr[wr_ptr] <= i_alu_addr;
        fifo_data[wr_ptr] <= i_alu_data;
        wr_ptr            <= wr_ptr + PW'(1);
      end
    end
  end

`ifdef RF_WB_ERR_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_err <= 1'b0;
    end else if ((i_ld_valid && i_ld_addr != '0 && !pending[i_ld_addr]) ||
                 (i_ld_issue && !o_ld_issue_ready)) begin
      o_err <= 1'b1;
    end
  end
`else
  assign o_err = 1'b0;
`endif

endmodule

// File: tb/tb_rf_wb_arbiter.sv
module tb_rf_wb_arbiter;
  localparam int W  = 32;
  localparam int D  = 32;
  localparam int FD = 2;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          i_alu_valid = 1'b0;
  logic          o_alu_ready;
  logic [AW-1:0] i_alu_addr = '0;
  logic [W-1:0]  i_alu_data = '0;
  logic          i_ld_issue = 1'b0;
  logic [AW-1:0] i_ld_issue_addr = '0;
  logic          o_ld_issue_ready;
  logic          i_ld_valid = 1'b0;
  logic [AW-1:0] i_ld_addr = '0;
  logic [W-1:0]  i_ld_data = '0;
  logic [AW-1:0] i_rs1_addr = '0;
  logic [AW-1:0] i_rs2_addr = '0;
  logic          o_stall;
  logic          o_wr_en;
  logic [AW-1:0] o_wr_addr;
  logic [W-1:0]  o_wr_data;
  logic          o_err;

  rf_wb_arbiter #(.WIDTH(W), .DEPTH(D), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_alu_valid(i_alu_valid), .o_alu_ready(o_alu_ready),
    .i_alu_addr(i_alu_addr), .i_alu_data(i_alu_data),
    .i_ld_issue(i_ld_issue), .i_ld_issue_addr(i_ld_issue_addr),
    .o_ld_issue_ready(o_ld_issue_ready),
    .i_ld_valid(i_ld_valid), .i_ld_addr(i_ld_addr), .i_ld_data(i_ld_data),
    .i_rs1_addr(i_rs1_addr), .i_rs2_addr(i_rs2_addr), .o_stall(o_stall),
    .o_wr_en(o_wr_en), .o_wr_addr(o_wr_addr), .o_wr_data(o_wr_data),
    .o_err(o_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string nm, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference model: a set of registers with loads in flight, an ordered list
  // of ALU results waiting for the port, and the scoreboard of expected writes.
  typedef struct { logic [AW-1:0] addr; logic [W-1:0] data; int due; } wr_t;
  bit  pend [D];
  wr_t wq [$];
  wr_t exp_q [$];
  bit  m_err = 0;

  function automatic bit m_hit(logic [AW-1:0] r);
    if (r == 0) return 0;
    if (pend[r]) return 1;
    foreach (wq[i]) if (wq[i].addr == r) return 1;
    return 0;
  endfunction

  function automatic void expect_write(logic [AW-1:0] a, logic [W-1:0] d);
    wr_t e;
    if (a == 0) return;
    e.addr = a; e.data = d; e.due = cyc + 1;
    exp_q.push_back(e);
  endfunction

  // Monitor: every write the DUT makes must be the next one the model predicted,
  // in the cycle it was predicted for.
  always @(negedge clk) begin
    wr_t e;
    if (rst_n) begin
      if (exp_q.size() > 0 && exp_q[0].due < cyc) begin
        check("wr_late", cyc, exp_q[0].due);
        void'(exp_q.pop_front());
      end
      if (o_wr_en) begin
        if (exp_q.size() == 0) check("wr_unexpected", o_wr_en, 0);
        else begin
          e = exp_q.pop_front();
          check("wr_addr", o_wr_addr, e.addr);
          check("wr_data", o_wr_data, e.data);
          check("wr_cycle", cyc, e.due);
        end
      end else if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
        check("wr_missing", o_wr_en, 1);
      end
    end
  end

  // One clock cycle of stimulus; called 1 time unit after a rising edge.
  task automatic step(input bit av, input int aa, input logic [W-1:0] ad,
                      input bit iv, input int ia,
                      input bit lv, input int la, input logic [W-1:0] ld,
                      input int r1, input int r2);
    bit  alu_rdy, iss_rdy, acc;
    wr_t w;
    i_alu_valid = av; i_alu_addr = AW'(aa); i_alu_data = ad;
    i_ld_issue = iv; i_ld_issue_addr = AW'(ia);
    i_ld_valid = lv; i_ld_addr = AW'(la); i_ld_data = ld;
    i_rs1_addr = AW'(r1); i_rs2_addr = AW'(r2);
    #1;
    alu_rdy = (wq.size() < FD) && !pend[aa];
    iss_rdy = !pend[ia];
    check("alu_ready", o_alu_ready, alu_rdy);
    check("issue_ready", o_ld_issue_ready, iss_rdy);
    check("stall", o_stall, m_hit(AW'(r1)) || m_hit(AW'(r2)));
    acc = av && alu_rdy;
`ifdef RF_WB_ERR_EN
    if ((lv && la != 0 && !pend[la]) || (iv && !iss_rdy)) m_err = 1;
`endif
    if (lv) begin
      expect_write(AW'(la), ld);
      if (acc) begin w.addr = AW'(aa); w.data = ad; w.due = 0; wq.push_back(w); end
    end else if (wq.size() > 0) begin
      w = wq.pop_front();
      expect_write(w.addr, w.data);
      if (acc) begin w.addr = AW'(aa); w.data = ad; w.due = 0; wq.push_back(w); end
    end else if (acc) begin
      expect_write(AW'(aa), ad);
    end
    if (lv) pend[la] = 0;
    if (iv && iss_rdy && ia != 0) pend[ia] = 1;
    @(posedge clk); #1;
    check("err", o_err, m_err);
  endtask

  task automatic idle(input int n, input int r1, input int r2);
    for (int k = 0; k < n; k++) step(0, 0, 0, 0, 0, 0, 0, 0, r1, r2);
  endtask

  task automatic do_reset();
    rst_n = 0;
    i_alu_valid = 0; i_ld_issue = 0; i_ld_valid = 0;
    i_alu_addr = 5'd9; i_ld_issue_addr = 5'd9; i_rs1_addr = 5'd9; i_rs2_addr = 5'd3;
    foreach (pend[i]) pend[i] = 0;
    wq.delete(); exp_q.delete(); m_err = 0;
    #2;
    check("rst_wr_en", o_wr_en, 0);
    check("rst_wr_addr", o_wr_addr, 0);
    check("rst_wr_data", o_wr_data, 0);
    check("rst_err", o_err, 0);
    check("rst_alu_ready", o_alu_ready, 1);
    check("rst_issue_ready", o_ld_issue_ready, 1);
    check("rst_stall", o_stall, 0);
    @(posedge clk); #1;
    rst_n = 1;
    @(posedge clk); #1;
  endtask

  initial begin
    int la, np;
    do_reset();

    // load x5 returns 3 cycles after issue; rs1=5 stalls until the return
    step(0, 0, 0, 1, 5, 0, 0, 0, 5, 0);
    idle(2, 5, 0);
    step(0, 0, 0, 0, 0, 1, 5, 32'hDEADBEEF, 5, 0);
    idle(2, 5, 0);

    // ALU x3 and load x7 return in the same cycle
    step(0, 0, 0, 1, 7, 0, 0, 0, 0, 3);
    step(1, 3, 32'h11, 0, 0, 1, 7, 32'h22, 0, 3);
    idle(3, 0, 3);

    // three back-to-back returns with ALU results offered alongside
    step(0, 0, 0, 1, 10, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 11, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 12, 0, 0, 0, 0, 0);
    step(1, 1, 32'hA1, 0, 0, 1, 10, 32'h100, 1, 2);
    step(1, 2, 32'hA2, 0, 0, 1, 11, 32'h101, 1, 2);
    step(1, 13, 32'hA3, 0, 0, 1, 12, 32'h102, 13, 2);
    step(1, 13, 32'hA3, 0, 0, 0, 0, 0, 13, 1);
    step(1, 13, 32'hA3, 0, 0, 0, 0, 0, 13, 1);
    idle(4, 13, 2);

    // ALU write to x9 is held off while a load to x9 is outstanding
    step(0, 0, 0, 1, 9, 0, 0, 0, 9, 0);
    step(1, 9, 32'h99, 0, 0, 0, 0, 0, 9, 0);
    step(1, 9, 32'h99, 1, 9, 0, 0, 0, 9, 0);
    step(1, 9, 32'h99, 0, 0, 1, 9, 32'h900, 9, 0);
    step(1, 9, 32'h99, 0, 0, 0, 0, 0, 9, 0);
    idle(3, 9, 0);

    // writes to x0 are swallowed and never stall
    step(1, 0, 32'hFF, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 1, 0, 32'h1, 0, 0);
    idle(3, 0, 0);

    // reset in the middle of traffic discards pending marks and buffered results
    step(0, 0, 0, 1, 9, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 6, 0, 0, 0, 0, 0);
    step(1, 3, 32'h33, 0, 0, 1, 6, 32'h66, 0, 0);
    do_reset();

    // return to x4 without an issue: o_err (when built) sets and holds
    step(0, 0, 0, 0, 0, 1, 4, 32'h44, 0, 0);
    step(1, 2, 32'h22, 1, 8, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 8, 32'h88, 0, 0);
    idle(2, 0, 0);
    do_reset();

    // randomized traffic over a small register window to force collisions
    for (int n = 0; n < 600; n++) begin
      np = 0; la = 0;
      for (int r = 1; r < 8; r++) if (pend[r]) begin
        np++;
        if ($urandom_range(0, np - 1) == 0) la = r;
      end
      step($urandom_range(0, 1) == 1, int'($urandom_range(0, 7)), $urandom,
           $urandom_range(0, 3) == 0, int'($urandom_range(0, 7)),
           np > 0 && $urandom_range(0, 2) == 0, la, $urandom,
           int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
    end
    idle(6, 0, 0);
    check("drain_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
